// File: rtl/mmio_uart_fifo.sv
// mmio_uart_fifo
//   Memory-mapped, FIFO-buffered front end for the UART. It sits in the CPU's
//   I/O window and buffers characters in both directions. It keeps sticky
//   error flags and drives level interrupts towards COP0.
//
// Ports
//   clk, rst          system clock, asynchronous active-low reset
//   addr[4:2]         register select (addr[1:0] ignored)
//   re, we, stall     CPU strobes; stall masks both
//   wdata / rdata     CPU write data / combinational read data
//   tx_data/valid/ready   towards UART DataIn
//   rx_data/valid/ready   from UART DataOut
//   rx_irq, tx_irq    registered level interrupts
//
// Register map (addr[4:2])
//   0 STATUS  {tx_empty, rx_underflow, tx_overflow, tx_notfull, rx_nonempty}
//   1 RXDATA  read pops the RX head (0 when empty)
//   2 TXDATA  write pushes wdata[DATA_W-1:0]
//   3 COUNT   [23:16] tx_count, [7:0] rx_count
//   4 CTRL    bit0 rx_irq_en, bit1 tx_irq_en, [15:8] rx_thresh, bit31 W1 clears sticky flags
module mmio_uart_fifo #(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        addr,
    input  logic              re,
    input  logic              we,
    input  logic              stall,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rx_irq,
    output logic              tx_irq
);

    localparam int MAX_D = (RX_DEPTH > TX_DEPTH) ? RX_DEPTH : TX_DEPTH;
    localparam int CNT_W = $clog2(MAX_D) + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int CMP_W = (CNT_W > 8) ? CNT_W : 8;

    localparam logic [CNT_W-1:0] RX_FULL = CNT_W'(RX_DEPTH);
    localparam logic [CNT_W-1:0] TX_FULL = CNT_W'(TX_DEPTH);

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_TXDATA = 3'd2;
    localparam logic [2:0] REG_COUNT  = 3'd3;
    localparam logic [2:0] REG_CTRL   = 3'd4;

    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [RX_AW-1:0]  rx_rd_ptr, rx_wr_ptr;
    logic [TX_AW-1:0]  tx_rd_ptr, tx_wr_ptr;
    logic [CNT_W-1:0]  rx_count, tx_count, rx_count_next, tx_count_next;
    logic              tx_ovf, rx_unf;
    logic              rx_irq_en, tx_irq_en;
    logic [7:0]        rx_thresh, thresh_eff;

    logic [2:0] sel;
    logic       acc_wr, acc_rd;
    logic       rx_empty, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_pop_req, rx_unf_set;
    logic       tx_push, tx_pop, tx_push_req, tx_ovf_set;
    logic       ctrl_wr;

    // Unused bus bits are folded here so they do not look forgotten.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

    assign sel    = addr[4:2];
    assign acc_wr = we & ~stall;
    // A write in the same cycle suppresses the read's side effect.
    assign acc_rd = re & ~stall & ~acc_wr;

    assign rx_empty = (rx_count == '0);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_FULL);

    assign rx_ready   = (rx_count != RX_FULL);
    assign rx_push    = rx_valid & rx_ready;
    assign rx_pop_req = acc_rd & (sel == REG_RXDATA);
    // Emptiness is judged before the edge: a same-cycle push cannot rescue an empty read.
    assign rx_pop     = rx_pop_req & ~rx_empty;
    assign rx_unf_set = rx_pop_req & rx_empty;

    assign tx_valid    = ~tx_empty;
    assign tx_data     = tx_mem[tx_rd_ptr];
    assign tx_pop      = tx_valid & tx_ready;
    assign tx_push_req = acc_wr & (sel == REG_TXDATA);
    // Fullness is judged before the edge: a same-cycle pop does not make room.
    assign tx_push     = tx_push_req & ~tx_full;
    assign tx_ovf_set  = tx_push_req & tx_full;

    assign ctrl_wr = acc_wr & (sel == REG_CTRL);

    always_comb begin
        rx_count_next = rx_count;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_next = rx_count + CNT_W'(1);
            2'b01:   rx_count_next = rx_count - CNT_W'(1);
            default: rx_count_next = rx_count;
        endcase
    end

    always_comb begin
        tx_count_next = tx_count;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count + CNT_W'(1);
            2'b01:   tx_count_next = tx_count - CNT_W'(1);
            default: tx_count_next = tx_count;
        endcase
    end

    assign thresh_eff = (rx_thresh == 8'd0) ? 8'd1 : rx_thresh;

    // Storage carries no reset; the pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= wdata[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            rx_count  <= '0;
            tx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            rx_count <= rx_count_next;
            tx_count <= tx_count_next;
        end
    end

    // Sticky flags and CTRL. Set and clear never coincide: set needs a
    // TXDATA write or RXDATA read, clear needs a CTRL write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ovf    <= 1'b0;
            rx_unf    <= 1'b0;
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
            rx_thresh <= 8'd1;
        end else begin
            if (tx_ovf_set) tx_ovf <= 1'b1;
            if (rx_unf_set) rx_unf <= 1'b1;
            if (ctrl_wr) begin
                rx_irq_en <= wdata[0];
                tx_irq_en <= wdata[1];
                rx_thresh <= wdata[15:8];
                if (wdata[31]) begin
                    tx_ovf <= 1'b0;
                    rx_unf <= 1'b0;
                end
            end
        end
    end

    // Interrupts look at the post-edge occupancy so they track the FIFOs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_irq <= 1'b0;
            tx_irq <= 1'b0;
        end else begin
            rx_irq <= rx_irq_en & (CMP_W'(rx_count_next) >= CMP_W'(thresh_eff));
            tx_irq <= tx_irq_en & (tx_count_next == '0);
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (sel)
            REG_STATUS: rdata = {27'd0, tx_empty, rx_unf, tx_ovf, ~tx_full, ~rx_empty};
            REG_RXDATA: rdata = rx_empty ? 32'd0 : 32'(rx_mem[rx_rd_ptr]);
            REG_COUNT:  rdata = {8'd0, 8'(tx_count), 8'd0, 8'(rx_count)};
            REG_CTRL:   rdata = {16'd0, rx_thresh, 6'd0, tx_irq_en, rx_irq_en};
            default:    rdata = 32'd0;
        endcase
    end

endmodule
